// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the packed-BCD seven-segment scan driver.
// Holds segment patterns (active-high, bit order {g,f,e,d,c,b,a}), the
// handshake FSM state enum, digit index / digit-select constants, and the
// packed BCD payload struct.
package bcd_disp_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned BCD_W = 2 * NIB_W;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned DIG_W = 2;

    // Active-high segment patterns
    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // Digit index: which nibble is being scanned
    localparam logic DIG_ONES = 1'b0;
    localparam logic DIG_TENS = 1'b1;

    // One-hot digit enables (active-high, before polarity)
    localparam logic [DIG_W-1:0] DIG_SEL_NONE = 2'b00;
    localparam logic [DIG_W-1:0] DIG_SEL_ONES = 2'b01;
    localparam logic [DIG_W-1:0] DIG_SEL_TENS = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    typedef struct packed {
        logic [NIB_W-1:0] tens;
        logic [NIB_W-1:0] ones;
    } bcd_t;

    // True when a nibble is not a legal decimal digit
    function automatic logic nibble_err(input logic [NIB_W-1:0] nib);
        return nib > NIB_W'(9);
    endfunction

endpackage

// File: rtl/bcd_seg_scan_driver_if.sv
// Valid/ready handshake carrying one packed BCD value (tens [7:4], ones [3:0]).
// master: producer (drives bcd_valid, packed_bcd; samples bcd_ready)
// slave : scan driver (samples bcd_valid, packed_bcd; drives bcd_ready)
interface bcd_seg_scan_driver_if;
    import bcd_disp_pkg::*;

    logic bcd_valid;
    bcd_t packed_bcd;
    logic bcd_ready;

    modport master (
        output bcd_valid,
        output packed_bcd,
        input  bcd_ready
    );

    modport slave (
        input  bcd_valid,
        input  packed_bcd,
        output bcd_ready
    );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-high seven-segment pattern decoder.
// Ports:
//   nibble : 4-bit digit value; values above 9 decode to a dash
//   seg_c  : {g,f,e,d,c,b,a} active-high pattern
module bcd_to_7seg
    import bcd_disp_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        case (nibble)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scan_driver.sv
// Two-digit seven-segment scan driver fed by a packed BCD value.
// A value is accepted over valid/ready into a shadow register and only
// committed to the display at a scan-frame boundary (end of the tens slot),
// so a frame never shows tens and ones from different values.
//
// Parameters:
//   SCAN_DIV     : clk cycles each digit stays selected (>= 2)
//   COMMON_ANODE : 1 = seg/dig_sel active-low, 0 = active-high
// Optional build macro:
//   LEADING_ZERO_BLANK_EN : blank the tens digit when the displayed tens is 0
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   bus         : valid/ready BCD input (slave side)
//   seg         : {g,f,e,d,c,b,a}, registered, polarity per COMMON_ANODE
//   dig_sel     : one-hot digit enable (bit0 ones, bit1 tens), registered
//   update_done : one-cycle pulse after a new value is committed
//   bcd_err     : displayed value holds a nibble > 9
module bcd_seg_scan_driver
    import bcd_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter bit          COMMON_ANODE = 1'b0
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    bcd_seg_scan_driver_if.slave   bus,
    output logic [SEG_W-1:0]       seg,
    output logic [DIG_W-1:0]       dig_sel,
    output logic                   update_done,
    output logic                   bcd_err
);

    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [SEG_W-1:0] SEG_INV = COMMON_ANODE ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
    localparam logic [DIG_W-1:0] DIG_INV = COMMON_ANODE ? {DIG_W{1'b1}} : {DIG_W{1'b0}};

    logic [PRE_W-1:0] presc;
    logic             digit_idx;
    logic             tc_c;
    logic             frame_end_c;

    state_t           state;
    state_t           next_state;
    logic             load_c;
    logic             commit_c;

    bcd_t             shadow;
    bcd_t             display;

    logic [NIB_W-1:0] nib_c;
    logic [SEG_W-1:0] dec_c;
    logic             blank_c;
    logic [SEG_W-1:0] pat_c;
    logic [DIG_W-1:0] dsel_c;

    // Scan prescaler and digit index
    assign tc_c        = (presc == PRE_W'(SCAN_DIV - 1));
    assign frame_end_c = tc_c && (digit_idx == DIG_TENS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc     <= '0;
            digit_idx <= DIG_ONES;
        end else if (tc_c) begin
            presc     <= '0;
            digit_idx <= ~digit_idx;
        end else begin
            presc     <= presc + PRE_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.bcd_valid) next_state = PEND;
            PEND:    if (frame_end_c)   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs; ready is held low while reset is asserted
    always_comb begin
        bus.bcd_ready = 1'b0;
        load_c        = 1'b0;
        commit_c      = 1'b0;
        case (state)
            IDLE: begin
                bus.bcd_ready = rst_n;
                load_c        = bus.bcd_valid;
            end
            PEND: begin
                commit_c      = frame_end_c;
            end
            default: begin
                bus.bcd_ready = 1'b0;
            end
        endcase
    end

    // Shadow register holds the accepted value until the frame boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (load_c) begin
            shadow <= bus.packed_bcd;
        end
    end

    // Display commit, completion pulse and error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            display     <= '0;
            update_done <= 1'b0;
            bcd_err     <= 1'b0;
        end else begin
            update_done <= commit_c;
            if (commit_c) begin
                display <= shadow;
                bcd_err <= nibble_err(shadow.tens) || nibble_err(shadow.ones);
            end
        end
    end

    // Nibble mux feeding the single shared decoder
    assign nib_c = (digit_idx == DIG_TENS) ? display.tens : display.ones;

    bcd_to_7seg u_dec (
        .nibble (nib_c),
        .seg_c  (dec_c)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign blank_c = (digit_idx == DIG_TENS) && (display.tens == NIB_W'(0));
`else
    assign blank_c = 1'b0;
`endif

    assign pat_c  = blank_c ? SEG_BLANK : dec_c;
    assign dsel_c = (digit_idx == DIG_TENS) ? DIG_SEL_TENS : DIG_SEL_ONES;

    // Output registers with polarity applied at the pins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg     <= SEG_BLANK ^ SEG_INV;
            dig_sel <= DIG_SEL_NONE ^ DIG_INV;
        end else begin
            seg     <= pat_c ^ SEG_INV;
            dig_sel <= dsel_c ^ DIG_INV;
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan_driver.sv
// Directed self-checking bench for bcd_seg_scan_driver (SCAN_DIV=4, common cathode).
module tb_bcd_seg_scan_driver;
    import bcd_disp_pkg::*;

    localparam int unsigned SCAN_DIV = 4;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] TENS_ZERO = 7'h00;
`else
    localparam logic [6:0] TENS_ZERO = 7'h3F;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg;
    logic [1:0] dig_sel;
    logic       update_done;
    logic       bcd_err;

    int tests_run    = 0;
    int tests_failed = 0;

    bcd_seg_scan_driver_if bus();

    bcd_seg_scan_driver #(
        .SCAN_DIV     (SCAN_DIV),
        .COMMON_ANODE (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .seg         (seg),
        .dig_sel     (dig_sel),
        .update_done (update_done),
        .bcd_err     (bcd_err)
    );

    always #5 clk = ~clk;

    // Drive one value for a single cycle; returns at the negedge after the accepting edge
    task automatic send(input logic [7:0] v);
        bus.bcd_valid  = 1'b1;
        bus.packed_bcd = v;
        @(negedge clk);
        bus.bcd_valid  = 1'b0;
    endtask

    // Poll update_done on up to max_cycles negedges
    task automatic wait_done(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (update_done === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Advance to the next negedge where dig_sel equals want (bounded)
    task automatic wait_dig(input logic [1:0] want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * SCAN_DIV; i++) begin
            @(negedge clk);
            if (dig_sel === want) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        logic [1:0] exp_dig;
        logic [6:0] exp_seg;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (seg !== 7'h00) begin tests_failed++; $display("FAIL reset_seg: got %h expected 00", seg); end
        tests_run++;
        if (dig_sel !== 2'b00) begin tests_failed++; $display("FAIL reset_dig_sel: got %b expected 00", dig_sel); end
        tests_run++;
        if (bus.bcd_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", bus.bcd_ready); end
        tests_run++;
        if (bcd_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", bcd_err); end
        tests_run++;
        if (update_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", update_done); end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (bus.bcd_ready !== 1'b1) begin tests_failed++; $display("FAIL release_ready: got %b expected 1", bus.bcd_ready); end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_dig = (((k - 1) / 4) % 2 == 1) ? 2'b10 : 2'b01;
            exp_seg = (exp_dig == 2'b10) ? TENS_ZERO : 7'h3F;
            tests_run++;
            if (dig_sel !== exp_dig) begin tests_failed++; $display("FAIL scan_dig_sel[%0d]: got %b expected %b", k, dig_sel, exp_dig); end
            tests_run++;
            if (seg !== exp_seg) begin tests_failed++; $display("FAIL scan_seg[%0d]: got %h expected %h", k, seg, exp_seg); end
        end
    endtask

    task automatic test_single_update();
        bit ok;
        @(negedge clk);
        tests_run++;
        if (bus.bcd_ready !== 1'b1) begin tests_failed++; $display("FAIL single_ready_idle: got %b expected 1", bus.bcd_ready); end
        send(8'h42);
        tests_run++;
        if (bus.bcd_ready !== 1'b0) begin tests_failed++; $display("FAIL single_ready_drop: got %b expected 0", bus.bcd_ready); end
        wait_done(2 * SCAN_DIV, ok);
        tests_run++;
        if (ok !== 1'b1) begin tests_failed++; $display("FAIL single_done_latency: got no pulse expected pulse within %0d cycles", 2 * SCAN_DIV + 1); end
        tests_run++;
        if (bus.bcd_ready !== 1'b1) begin tests_failed++; $display("FAIL single_ready_back: got %b expected 1", bus.bcd_ready); end
        tests_run++;
        if (bcd_err !== 1'b0) begin tests_failed++; $display("FAIL single_err: got %b expected 0", bcd_err); end
        @(negedge clk);
        tests_run++;
        if (update_done !== 1'b0) begin tests_failed++; $display("FAIL single_done_width: got %b expected 0", update_done); end
        wait_dig(2'b01, ok);
        tests_run++;
        if (ok !== 1'b1 || seg !== 7'h5B) begin tests_failed++; $display("FAIL single_ones_seg: got %h expected 5b", seg); end
        wait_dig(2'b10, ok);
        tests_run++;
        if (ok !== 1'b1 || seg !== 7'h66) begin tests_failed++; $display("FAIL single_tens_seg: got %h expected 66", seg); end
    endtask

    task automatic test_back_to_back();
        int         done_cnt;
        int         stage;
        int         pstage;
        bit         acc34;
        bit         ones_ok;
        logic [6:0] o_seg;
        logic [1:0] prev_dig;
        @(negedge clk);
        tests_run++;
        if (bus.bcd_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_idle: got %b expected 1", bus.bcd_ready); end
        bus.bcd_valid  = 1'b1;
        bus.packed_bcd = 8'h12;
        @(negedge clk);
        bus.packed_bcd = 8'h34;
        done_cnt = 0;
        stage    = 0;
        acc34    = 1'b0;
        ones_ok  = 1'b0;
        o_seg    = 7'h00;
        prev_dig = dig_sel;
        for (int i = 0; i < 48; i++) begin
            if (update_done === 1'b1) done_cnt++;
            if (acc34) begin
                bus.bcd_valid = 1'b0;
            end else if (bus.bcd_ready === 1'b1) begin
                acc34 = 1'b1;
                tests_run++;
                if (done_cnt != 1) begin tests_failed++; $display("FAIL b2b_accept_order: got %0d commits before accept expected 1", done_cnt); end
            end
            if (dig_sel === 2'b01) begin
                o_seg   = seg;
                ones_ok = 1'b1;
            end else if (dig_sel === 2'b10 && prev_dig === 2'b01 && ones_ok) begin
                // Completed frame: identify the value and require monotonic progress 42 -> 12 -> 34
                case ({o_seg, seg})
                    {7'h5B, 7'h66}: pstage = 0;
                    {7'h5B, 7'h06}: pstage = 1;
                    {7'h66, 7'h4F}: pstage = 2;
                    default:        pstage = -1;
                endcase
                tests_run++;
                if (pstage < stage) begin
                    tests_failed++;
                    $display("FAIL b2b_frame: got ones %h tens %h expected frame of 0x42/0x12/0x34 in order", o_seg, seg);
                end else begin
                    stage = pstage;
                end
            end
            prev_dig = dig_sel;
            @(negedge clk);
        end
        bus.bcd_valid = 1'b0;
        tests_run++;
        if (done_cnt != 2) begin tests_failed++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt); end
        tests_run++;
        if (acc34 !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept34: got %b expected 1", acc34); end
        tests_run++;
        if (stage != 2) begin tests_failed++; $display("FAIL b2b_final_frame: got stage %0d expected 2", stage); end
    endtask

    task automatic test_invalid();
        bit ok;
        @(negedge clk);
        tests_run++;
        if (bus.bcd_ready !== 1'b1) begin tests_failed++; $display("FAIL inv_ready_idle: got %b expected 1", bus.bcd_ready); end
        send(8'h3A);
        wait_done(2 * SCAN_DIV, ok);
        tests_run++;
        if (ok !== 1'b1) begin tests_failed++; $display("FAIL inv_done: got no pulse expected pulse"); end
        tests_run++;
        if (bcd_err !== 1'b1) begin tests_failed++; $display("FAIL inv_err_set: got %b expected 1", bcd_err); end
        wait_dig(2'b01, ok);
        tests_run++;
        if (ok !== 1'b1 || seg !== 7'h40) begin tests_failed++; $display("FAIL inv_ones_dash: got %h expected 40", seg); end
        wait_dig(2'b10, ok);
        tests_run++;
        if (ok !== 1'b1 || seg !== 7'h4F) begin tests_failed++; $display("FAIL inv_tens_seg: got %h expected 4f", seg); end
        send(8'h05);
        tests_run++;
        if (bcd_err !== 1'b1) begin tests_failed++; $display("FAIL inv_err_hold: got %b expected 1", bcd_err); end
        wait_done(2 * SCAN_DIV, ok);
        tests_run++;
        if (ok !== 1'b1) begin tests_failed++; $display("FAIL inv_done2: got no pulse expected pulse"); end
        tests_run++;
        if (bcd_err !== 1'b0) begin tests_failed++; $display("FAIL inv_err_clear: got %b expected 0", bcd_err); end
        wait_dig(2'b01, ok);
        tests_run++;
        if (ok !== 1'b1 || seg !== 7'h6D) begin tests_failed++; $display("FAIL inv_ones5_seg: got %h expected 6d", seg); end
        wait_dig(2'b10, ok);
        tests_run++;
        if (ok !== 1'b1 || seg !== TENS_ZERO) begin tests_failed++; $display("FAIL inv_tens0_seg: got %h expected %h", seg, TENS_ZERO); end
    endtask

    task automatic test_reset_pend();
        bit done_seen;
        @(negedge clk);
        tests_run++;
        if (bus.bcd_ready !== 1'b1) begin tests_failed++; $display("FAIL rp_ready_idle: got %b expected 1", bus.bcd_ready); end
        send(8'h99);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.bcd_ready !== 1'b0) begin tests_failed++; $display("FAIL rp_ready_in_reset: got %b expected 0", bus.bcd_ready); end
        done_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (update_done === 1'b1) done_seen = 1'b1;
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (bus.bcd_ready !== 1'b1) begin tests_failed++; $display("FAIL rp_ready_release: got %b expected 1", bus.bcd_ready); end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (update_done === 1'b1) done_seen = 1'b1;
            if (dig_sel === 2'b01) begin
                tests_run++;
                if (seg !== 7'h3F) begin tests_failed++; $display("FAIL rp_ones_seg[%0d]: got %h expected 3f", k, seg); end
            end else begin
                tests_run++;
                if (seg !== TENS_ZERO) begin tests_failed++; $display("FAIL rp_tens_seg[%0d]: got %h expected %h", k, seg, TENS_ZERO); end
            end
        end
        tests_run++;
        if (done_seen !== 1'b0) begin tests_failed++; $display("FAIL rp_no_done: got pulse expected none"); end
        tests_run++;
        if (bcd_err !== 1'b0) begin tests_failed++; $display("FAIL rp_err: got %b expected 0", bcd_err); end
    endtask

    task automatic test_leading_zero();
        bit ok;
        @(negedge clk);
        tests_run++;
        if (bus.bcd_ready !== 1'b1) begin tests_failed++; $display("FAIL lz_ready_idle: got %b expected 1", bus.bcd_ready); end
        send(8'h07);
        wait_done(2 * SCAN_DIV, ok);
        tests_run++;
        if (ok !== 1'b1) begin tests_failed++; $display("FAIL lz_done: got no pulse expected pulse"); end
        wait_dig(2'b01, ok);
        tests_run++;
        if (ok !== 1'b1 || seg !== 7'h07) begin tests_failed++; $display("FAIL lz_ones_seg: got %h expected 07", seg); end
        wait_dig(2'b10, ok);
        tests_run++;
        if (ok !== 1'b1 || seg !== TENS_ZERO) begin tests_failed++; $display("FAIL lz_tens_seg: got %h expected %h", seg, TENS_ZERO); end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.bcd_valid  = 1'b0;
        bus.packed_bcd = '0;
        test_reset();
        test_single_update();
        test_back_to_back();
        test_invalid();
        test_reset_pend();
        test_leading_zero();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bcd_seg_scan_driver.md
Name: bcd_seg_scan_driver

Overview:
Downstream consumer of the binary-to-BCD converter's 8-bit packed BCD output (tens nibble [7:4], ones nibble [3:0], values 0–99).
- Accepts a value over a valid/ready handshake and holds it in a shadow register.
- Commits it to the display at a scan-frame boundary, so no digit shows a mix of old and new values.
- Time-multiplexes two seven-segment digits.

Parameters:
SCAN_DIV, 1000, clk cycles each digit stays selected (min 2)
COMMON_ANODE, 0, 1 = seg and dig_sel outputs active-low; 0 = active-high

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
bcd_valid  input  1  packed_bcd holds a new value
packed_bcd  input  8  [7:4] tens, [3:0] ones
bcd_ready  output  1  block can accept a value this cycle
seg  output  7  {g,f,e,d,c,b,a}, polarity per COMMON_ANODE
dig_sel  output  2  one-hot digit enable: bit0 = ones, bit1 = tens
update_done  output  1  one-cycle pulse when a new value reaches the display
bcd_err  output  1  high while the displayed value contains a nibble > 9

Behaviour:
- Reset: synchronous, active-low, takes effect on a clk edge with rst_n=0.
  - Prescaler = 0, digit_idx = 0, shadow = 0x00, display = 0x00, state = IDLE.
  - seg = blank, dig_sel = none enabled (both after polarity), update_done = 0, bcd_err = 0.
  - bcd_ready is forced 0 while rst_n = 0.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. At terminal count (tc), digit_idx toggles.
- Frame boundary: tc && digit_idx == 1.
- FSM:
  - IDLE: bcd_ready = 1. bcd_valid && bcd_ready loads shadow and moves to PEND.
  - PEND: bcd_ready = 0. At the frame boundary: display <= shadow, update_done = 1 on the next cycle, state returns to IDLE.
- A commit and a new bcd_valid in the same cycle: the value is not accepted, because ready = 0 in PEND. Acceptance becomes possible the following cycle.
- Latency, accept to display: at most 2*SCAN_DIV+1 cycles.
- Outputs: seg and dig_sel are registered from digit_idx and display, so they lag digit_idx by 1 cycle.
  - digit_idx 0 drives the ones digit: dig_sel = 01.
  - digit_idx 1 drives the tens digit: dig_sel = 10.
- Decode (active-high patterns): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Any nibble > 9 shows dash = 40. Blank = 00.
- bcd_err: updated at commit to (tens > 9) || (ones > 9); holds until the next commit.
- Polarity: COMMON_ANODE = 1 inverts both seg and dig_sel at the output registers.
- Reset during PEND: the pending value is discarded, display stays 0x00, no update_done pulse.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: when the displayed tens nibble is 0, the tens digit seg = blank; dig_sel still scans normally.
- Undefined: a tens nibble of 0 displays "0" (3F).
- The ones digit is never blanked in either case.

Decomposition:
- Package bcd_disp_pkg holds:
  - the seven-segment pattern constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK);
  - the state enum {IDLE, PEND};
  - the digit index constants.
- Sub-module bcd_to_7seg: combinational nibble-to-pattern decoder. Instantiated once, fed by a nibble mux selected by digit_idx.

Test Plan:
All scenarios use SCAN_DIV=4 and COMMON_ANODE=0.
1. Reset hold: rst_n low for 3 cycles -> seg=00, dig_sel=00, bcd_ready=0, bcd_err=0. After release -> bcd_ready=1; then dig_sel alternates 01/10 every 4 cycles with seg=3F.
2. Single update 0x42 -> bcd_ready drops the cycle after accept; update_done pulses once within 9 cycles; then dig_sel=01 gives seg=5B and dig_sel=10 gives seg=66.
3. Back-to-back: 0x12 accepted, then bcd_valid held with 0x34 -> 0x34 is accepted only after update_done for 0x12. The displayed sequence is 0x12 then 0x34, with no torn frame (tens and ones always from the same value).
4. Invalid input 0x3A -> ones seg=40, tens seg=4F, bcd_err=1. A following 0x05 clears bcd_err at its commit.
5. Reset mid-PEND: accept 0x99, pulse rst_n before the frame boundary -> display stays 0x00, no update_done, bcd_ready=1 after release.
6. Leading zero: send 0x07 -> tens seg=00 with LEADING_ZERO_BLANK_EN, 3F without. Ones seg=07 in both builds.
